// File: rtl/xprod_arbiter.sv
// ---------------------------------------------------------------------------
// xprod_arbiter
//
// Shares one cross-product compare unit between two requesters. Each
// operation computes P1 = ax*by and P2 = bx*ay as exact 22-bit signed
// products and reports their ordering to the requester that issued it.
//
// Arbitration is round-robin on a 1-bit priority register. The grant is
// combinational in the request cycle. Operands are captured at the edge
// that ends that cycle. The datapath is a 2-stage pipeline with full
// throughput. A response appears two cycles after its grant.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous active-high reset
//   req0, ax0..by0       requester 0 (sort engine) request + signed operands
//   req1, ax1..by1       requester 1 (inside-test engine) request + operands
//   gnt0, gnt1           grant for the current cycle (combinational)
//   rsp_valid0/1         response for requester 0 / 1 is on rsp_cmp
//   rsp_cmp              1: P1>P2, 0: P1<P2, 2: P1==P2 (0 when no response)
//   busy                 an operation is in flight in either stage
// ---------------------------------------------------------------------------
module xprod_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [10:0] ax0,
    input  logic [10:0] ay0,
    input  logic [10:0] bx0,
    input  logic [10:0] by0,
    input  logic        req1,
    input  logic [10:0] ax1,
    input  logic [10:0] ay1,
    input  logic [10:0] bx1,
    input  logic [10:0] by1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [1:0]  rsp_cmp,
    output logic        busy
);

    // Operand slots: 0 = ax, 1 = ay, 2 = bx, 3 = by
    logic [10:0] op0 [4];
    logic [10:0] op1 [4];
    logic [10:0] sel_op [4];

    logic        prio_reg;          // 0: requester 0 favoured
    logic        issue;

    logic        s1_valid_reg;
    logic        s1_tag_reg;        // 0: requester 0, 1: requester 1
    logic [10:0] s1_op_reg [4];

    logic        s2_valid_reg;
    logic        s2_tag_reg;
    logic signed [21:0] s2_p1_reg;
    logic signed [21:0] s2_p2_reg;

    logic signed [21:0] ax_ext, ay_ext, bx_ext, by_ext;
    logic signed [21:0] p1_next, p2_next;
    logic [1:0]         cmp_raw;

    assign op0[0] = ax0;
    assign op0[1] = ay0;
    assign op0[2] = bx0;
    assign op0[3] = by0;
    assign op1[0] = ax1;
    assign op1[1] = ay1;
    assign op1[2] = bx1;
    assign op1[3] = by1;

    // Round-robin grant. A lone requester always wins; on contention the
    // favoured one wins. Grants are forced low while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && (!req1 || !prio_reg)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign issue = gnt0 | gnt1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_op_mux
            assign sel_op[gi] = gnt1 ? op1[gi] : op0[gi];
        end
    endgenerate

    // Priority flips to the other requester after every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_reg <= 1'b0;
        end else if (issue) begin
            prio_reg <= gnt0;
        end
    end

    // Stage 1: operands and tag. Operands load only on issue so that they
    // do not toggle needlessly while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_tag_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s1_op_reg[i] <= '0;
            end
        end else begin
            s1_valid_reg <= issue;
            s1_tag_reg   <= issue ? gnt1 : 1'b0;
            if (issue) begin
                for (int i = 0; i < 4; i++) begin
                    s1_op_reg[i] <= sel_op[i];
                end
            end
        end
    end

    // Sign-extend to full product width so the multiply is exact: the
    // extreme case -1024 * -1024 = +1048576 needs all 22 bits.
    assign ax_ext  = {{11{s1_op_reg[0][10]}}, s1_op_reg[0]};
    assign ay_ext  = {{11{s1_op_reg[1][10]}}, s1_op_reg[1]};
    assign bx_ext  = {{11{s1_op_reg[2][10]}}, s1_op_reg[2]};
    assign by_ext  = {{11{s1_op_reg[3][10]}}, s1_op_reg[3]};
    assign p1_next = ax_ext * by_ext;
    assign p2_next = bx_ext * ay_ext;

    // Stage 2: products and tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_tag_reg   <= 1'b0;
            s2_p1_reg    <= '0;
            s2_p2_reg    <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_tag_reg   <= s1_valid_reg ? s1_tag_reg : 1'b0;
            if (s1_valid_reg) begin
                s2_p1_reg <= p1_next;
                s2_p2_reg <= p2_next;
            end
        end
    end

    // Signed compare of the stage-2 products.
    always_comb begin
        if (s2_p1_reg > s2_p2_reg) begin
            cmp_raw = 2'd1;
        end else if (s2_p1_reg < s2_p2_reg) begin
            cmp_raw = 2'd0;
        end else begin
            cmp_raw = 2'd2;
        end
    end

    assign rsp_valid0 = s2_valid_reg & ~s2_tag_reg;
    assign rsp_valid1 = s2_valid_reg &  s2_tag_reg;
    assign rsp_cmp    = s2_valid_reg ? cmp_raw : 2'd0;
    assign busy       = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_xprod_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xprod_arbiter
//
// Directed bench for xprod_arbiter. Inputs change 1 time unit after the
// rising edge. Outputs are sampled on the falling edge of the same cycle.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_xprod_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [10:0] ax0 = '0, ay0 = '0, bx0 = '0, by0 = '0;
    logic [10:0] ax1 = '0, ay1 = '0, bx1 = '0, by1 = '0;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, busy;
    logic [1:0]  rsp_cmp;

    int tests_run    = 0;
    int tests_failed = 0;

    xprod_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .ax0        (ax0),
        .ay0        (ay0),
        .bx0        (bx0),
        .by0        (by0),
        .req1       (req1),
        .ax1        (ax1),
        .ay1        (ay1),
        .bx1        (bx1),
        .by1        (by1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rsp_valid0 (rsp_valid0),
        .rsp_valid1 (rsp_valid1),
        .rsp_cmp    (rsp_cmp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops0(input int ax, input int ay, input int bx, input int by);
        ax0 = 11'(ax); ay0 = 11'(ay); bx0 = 11'(bx); by0 = 11'(by);
    endtask

    task automatic set_ops1(input int ax, input int ay, input int bx, input int by);
        ax1 = 11'(ax); ay1 = 11'(ay); bx1 = 11'(bx); by1 = 11'(by);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        set_ops0(3, 1, 1, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_cmp, busy} !== 7'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_outputs cyc%0d: got g0=%b g1=%b v0=%b v1=%b cmp=%0d busy=%b, want all 0",
                         i, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_cmp, busy);
            end
        end
        next_cycle();
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic reset_pulse();
        next_cycle();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Single issue on requester 0: 3*2=6 > 1*1=1 -> cmp 1 at T+2.
    task automatic test_single(input string tag);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) next_cycle();
        next_cycle();
        req0 = 1'b1;
        set_ops0(3, 1, 1, 2);
        @(negedge clk);
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_grant: got g0=%b g1=%b, want g0=1 g1=0", tag, gnt0, gnt1);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_busy_T: got %b, want 0", tag, busy);
        end
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_T+1: got busy=%b v0=%b v1=%b, want busy=1 v0=0 v1=0",
                     tag, busy, rsp_valid0, rsp_valid1);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (rsp_valid0 !== 1'b1 || rsp_valid1 !== 1'b0 || rsp_cmp !== 2'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_T+2: got v0=%b v1=%b cmp=%0d busy=%b, want v0=1 v1=0 cmp=1 busy=1",
                     tag, rsp_valid0, rsp_valid1, rsp_cmp, busy);
        end
        $display("[TB] %s: req0 (3,1,1,2) -> v0=%b cmp=%0d", tag, rsp_valid0, rsp_cmp);
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (rsp_valid0 !== 1'b0 || rsp_cmp !== 2'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_T+3: got v0=%b cmp=%0d busy=%b, want 0 0 0",
                     tag, rsp_valid0, rsp_cmp, busy);
        end
    endtask

    // Both requesters held from reset: grants 0,1,0,1. Requester 0 operands
    // give 6>1 (cmp 1), requester 1 operands give 1<10 (cmp 0).
    task automatic test_contention();
        logic exp_g0, exp_g1, exp_v0, exp_v1;
        logic [1:0] exp_cmp;
        reset_pulse();
        set_ops0(3, 1, 1, 2);
        set_ops1(1, 5, 2, 1);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            req0 = (k < 4);
            req1 = (k < 4);
            @(negedge clk);
            exp_g0  = (k < 4) && (k % 2 == 0);
            exp_g1  = (k < 4) && (k % 2 == 1);
            exp_v0  = (k >= 2) && (k % 2 == 0);
            exp_v1  = (k >= 2) && (k % 2 == 1);
            exp_cmp = exp_v0 ? 2'd1 : 2'd0;
            tests_run++;
            if (gnt0 !== exp_g0 || gnt1 !== exp_g1) begin
                tests_failed++;
                $display("[TB] FAIL contention_grant cyc%0d: got g0=%b g1=%b, want g0=%b g1=%b",
                         k, gnt0, gnt1, exp_g0, exp_g1);
            end
            tests_run++;
            if (rsp_valid0 !== exp_v0 || rsp_valid1 !== exp_v1 || rsp_cmp !== exp_cmp) begin
                tests_failed++;
                $display("[TB] FAIL contention_rsp cyc%0d: got v0=%b v1=%b cmp=%0d, want v0=%b v1=%b cmp=%0d",
                         k, rsp_valid0, rsp_valid1, rsp_cmp, exp_v0, exp_v1, exp_cmp);
            end
            $display("[TB] contention cyc%0d: g0=%b g1=%b v0=%b v1=%b cmp=%0d",
                     k, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_cmp);
        end
    endtask

    // Back-to-back on requester 1, new operands every granted cycle.
    task automatic test_compare_b2b();
        int         vax [6] = '{2, 1, -1024, -1024,  1023, 0};
        int         vay [6] = '{3, 5,     0, -1024, -1024, 0};
        int         vbx [6] = '{4, 2,     0, -1024, -1024, 0};
        int         vby [6] = '{6, 1, -1024, -1024,  1023, 0};
        logic [1:0] vexp [6] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
        logic       exp_v1;
        logic [1:0] exp_cmp;
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            if (k < 6) begin
                req1 = 1'b1;
                set_ops1(vax[k], vay[k], vbx[k], vby[k]);
            end else begin
                req1 = 1'b0;
            end
            @(negedge clk);
            tests_run++;
            if (gnt1 !== (k < 6) || gnt0 !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_grant cyc%0d: got g0=%b g1=%b, want g0=0 g1=%b",
                         k, gnt0, gnt1, (k < 6));
            end
            exp_v1  = (k >= 2) && (k < 8);
            exp_cmp = exp_v1 ? vexp[k-2] : 2'd0;
            tests_run++;
            if (rsp_valid1 !== exp_v1 || rsp_valid0 !== 1'b0 || rsp_cmp !== exp_cmp) begin
                tests_failed++;
                $display("[TB] FAIL b2b_rsp cyc%0d: got v0=%b v1=%b cmp=%0d, want v0=0 v1=%b cmp=%0d",
                         k, rsp_valid0, rsp_valid1, rsp_cmp, exp_v1, exp_cmp);
            end
            if (exp_v1)
                $display("[TB] b2b op%0d: v1=%b cmp=%0d", k - 2, rsp_valid1, rsp_cmp);
        end
    endtask

    // req1 held, req0 high every cycle. Priority starts at 0 here (the last
    // grant went to requester 1), so grants alternate 0,1,0,1,0,1.
    task automatic test_fairness();
        int since_g1 = 0;
        set_ops0(3, 1, 1, 2);
        set_ops1(1, 5, 2, 1);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            req0 = 1'b1;
            req1 = 1'b1;
            @(negedge clk);
            tests_run++;
            if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
                tests_failed++;
                $display("[TB] FAIL fairness_grant cyc%0d: got g0=%b g1=%b, want g0=%b g1=%b",
                         k, gnt0, gnt1, (k % 2 == 0), (k % 2 == 1));
            end
            since_g1 = (gnt1 === 1'b1) ? 0 : since_g1 + 1;
            tests_run++;
            if (since_g1 > 1) begin
                tests_failed++;
                $display("[TB] FAIL fairness_gap cyc%0d: got %0d cycles without gnt1, want <=1",
                         k, since_g1);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) next_cycle();
    endtask

    // Grant in T, reset pulsed in T+1: the operation must vanish.
    task automatic test_reset_midflight();
        next_cycle();
        req0 = 1'b1;
        set_ops0(3, 1, 1, 2);
        @(negedge clk);
        tests_run++;
        if (gnt0 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midflight_grant: got g0=%b, want 1", gnt0);
        end
        next_cycle();
        req0  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midflight_in_reset: got busy=%b v0=%b v1=%b, want 0 0 0",
                     busy, rsp_valid0, rsp_valid1);
        end
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || rsp_cmp !== 2'd0) begin
                tests_failed++;
                $display("[TB] FAIL midflight_after cyc%0d: got busy=%b v0=%b v1=%b cmp=%0d, want all 0",
                         k, busy, rsp_valid0, rsp_valid1, rsp_cmp);
            end
        end
        test_single("post_reset");
    endtask

    task automatic test_idle();
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge clk);
            tests_run++;
            if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_cmp, busy} !== 7'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle cyc%0d: got g0=%b g1=%b v0=%b v1=%b cmp=%0d busy=%b, want all 0",
                         k, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_cmp, busy);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single("single");
        test_contention();
        test_compare_b2b();
        test_fairness();
        test_reset_midflight();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
